track_window_ctrl: RTL and testbench

TRACK_WINDOW_CTRL -- requirements
Module: track_window_ctrl

---
 rtl/track_pkg.sv | 16 +
 rtl/win_clamp.sv | 41 ++++
 rtl/track_window_ctrl.sv | 170 +++++++++++++++++
 tb/tb_track_window_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/track_pkg.sv
// Shared tracker definitions: FSM state encoding and the fixed SEARCH-window limits.
package track_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCK   = 2'd1,
    COAST  = 2'd2
  } trk_state_t;

  // The right and bottom limits are given as offsets back from the active size.
  localparam int SRCH_LEFT       = 2;
  localparam int SRCH_RIGHT_OFS  = 2;
  localparam int SRCH_TOP        = 1;
  localparam int SRCH_BOTTOM_OFS = 2;

endpackage

// File: rtl/win_clamp.sv
// Combinational margin expansion of one box axis, saturated into [LIM_LO, LIM_HI].
module win_clamp #(
  parameter int W      = 11,
  parameter int MARGIN = 16,
  parameter int LIM_LO = 2,
  parameter int LIM_HI = 1278
) (
  input  logic [W-1:0] box_lo,
  input  logic [W-1:0] box_hi,
  output logic [W-1:0] win_lo,
  output logic [W-1:0] win_hi
);

  localparam logic [W+1:0] MARG_X = (W+2)'(MARGIN);
  localparam logic [W+1:0] LO_X   = (W+2)'(LIM_LO);
  localparam logic [W+1:0] HI_X   = (W+2)'(LIM_HI);

  logic [W+1:0] lo_ext;
  logic [W+1:0] hi_ext;

  // Two guard bits keep box_hi + MARGIN from wrapping.
  always_comb begin
    lo_ext = {2'b00, box_lo};
    hi_ext = {2'b00, box_hi} + MARG_X;

    if (lo_ext < MARG_X + LO_X)
      win_lo = W'(LIM_LO);
    else if (lo_ext - MARG_X > HI_X)
      win_lo = W'(LIM_HI);
    else
      win_lo = W'(lo_ext - MARG_X);

    if (hi_ext > HI_X)
      win_hi = W'(LIM_HI);
    else if (hi_ext < LO_X)
      win_hi = W'(LIM_LO);
    else
      win_hi = W'(hi_ext);
  end

endmodule

// File: rtl/track_window_ctrl.sv
// Detection-window controller: SEARCH/LOCK/COAST tracking, window updated 2 cycles after EOF.
// Optional TRACK_SMOOTH_EN averages successive LOCK windows per edge.
module track_window_ctrl
  import track_pkg::*;
#(
  parameter int H_ACT    = 1280,
  parameter int V_ACT    = 720,
  parameter int MARGIN   = 16,
  parameter int MIN_SIZE = 8,
  parameter int LOST_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] RGB_x_Src,
  input  logic [9:0]  RGB_y_Src,
  input  logic [10:0] Left,
  input  logic [10:0] Right,
  input  logic [9:0]  Top,
  input  logic [9:0]  Bottom,
  output logic [10:0] left_boundary,
  output logic [10:0] right_boundary,
  output logic [9:0]  top_boundary,
  output logic [9:0]  bottom_boundary,
  output logic        locked,
  output logic        frame_tick
);

  localparam int CNT_W = $clog2(LOST_MAX + 1);

  localparam logic [10:0] S_LEFT   = 11'(SRCH_LEFT);
  localparam logic [10:0] S_RIGHT  = 11'(H_ACT - SRCH_RIGHT_OFS);
  localparam logic [9:0]  S_TOP    = 10'(SRCH_TOP);
  localparam logic [9:0]  S_BOTTOM = 10'(V_ACT - SRCH_BOTTOM_OFS);

  function automatic logic [10:0] avg_h(input logic [10:0] a, input logic [10:0] b);
    logic [11:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[11:1];
  endfunction

  function automatic logic [9:0] avg_v(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[10:1];
  endfunction

  logic             eof_now, eof_d_p0, vld_p1;
  logic [10:0]      box_l_p1, box_r_p1;
  logic [9:0]       box_t_p1, box_b_p1;
  logic [10:0]      new_l, new_r, lk_l, lk_r;
  logic [9:0]       new_t, new_b, lk_t, lk_b;
  logic             hit;
  trk_state_t       state;
  logic [CNT_W-1:0] miss_cnt;

  assign eof_now = (RGB_x_Src == 11'(H_ACT - 1)) && (RGB_y_Src == 10'(V_ACT - 1));

  // Stage p1: edge-detected EOF samples the tracker box.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eof_d_p0 <= 1'b0;
      vld_p1   <= 1'b0;
      box_l_p1 <= '0;
      box_r_p1 <= '0;
      box_t_p1 <= '0;
      box_b_p1 <= '0;
    end else begin
      eof_d_p0 <= eof_now;
      vld_p1   <= eof_now && !eof_d_p0;
      if (eof_now && !eof_d_p0) begin
        box_l_p1 <= Left;
        box_r_p1 <= Right;
        box_t_p1 <= Top;
        box_b_p1 <= Bottom;
      end
    end
  end

  assign hit = ({1'b0, box_r_p1} >= {1'b0, box_l_p1} + 12'(MIN_SIZE)) &&
               ({1'b0, box_b_p1} >= {1'b0, box_t_p1} + 11'(MIN_SIZE));

  win_clamp #(.W(11), .MARGIN(MARGIN), .LIM_LO(SRCH_LEFT), .LIM_HI(H_ACT - SRCH_RIGHT_OFS))
    u_clamp_h (.box_lo(box_l_p1), .box_hi(box_r_p1), .win_lo(new_l), .win_hi(new_r));

  win_clamp #(.W(10), .MARGIN(MARGIN), .LIM_LO(SRCH_TOP), .LIM_HI(V_ACT - SRCH_BOTTOM_OFS))
    u_clamp_v (.box_lo(box_t_p1), .box_hi(box_b_p1), .win_lo(new_t), .win_hi(new_b));

  always_comb begin
`ifdef TRACK_SMOOTH_EN
    lk_l = avg_h(left_boundary, new_l);
    lk_r = avg_h(right_boundary, new_r);
    lk_t = avg_v(top_boundary, new_t);
    lk_b = avg_v(bottom_boundary, new_b);
`else
    lk_l = new_l;
    lk_r = new_r;
    lk_t = new_t;
    lk_b = new_b;
`endif
  end

  // Stage p2: FSM step on E+1, window and flags registered for E+2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= SEARCH;
      miss_cnt        <= '0;
      locked          <= 1'b0;
      frame_tick      <= 1'b0;
      left_boundary   <= S_LEFT;
      right_boundary  <= S_RIGHT;
      top_boundary    <= S_TOP;
      bottom_boundary <= S_BOTTOM;
    end else begin
      frame_tick <= vld_p1;
      if (vld_p1) begin
        case (state)
          SEARCH: begin
            miss_cnt <= '0;
            if (hit) begin
              state           <= LOCK;
              locked          <= 1'b1;
              left_boundary   <= new_l;
              right_boundary  <= new_r;
              top_boundary    <= new_t;
              bottom_boundary <= new_b;
            end else begin
              locked          <= 1'b0;
              left_boundary   <= S_LEFT;
              right_boundary  <= S_RIGHT;
              top_boundary    <= S_TOP;
              bottom_boundary <= S_BOTTOM;
            end
          end
          LOCK, COAST: begin
            if (hit) begin
              state           <= LOCK;
              miss_cnt        <= '0;
              locked          <= 1'b1;
              left_boundary   <= lk_l;
              right_boundary  <= lk_r;
              top_boundary    <= lk_t;
              bottom_boundary <= lk_b;
            end else if (state == LOCK) begin
              state    <= COAST;
              miss_cnt <= CNT_W'(1);
              locked   <= 1'b0;
            end else if (miss_cnt == CNT_W'(LOST_MAX - 1)) begin
              state           <= SEARCH;
              miss_cnt        <= '0;
              locked          <= 1'b0;
              left_boundary   <= S_LEFT;
              right_boundary  <= S_RIGHT;
              top_boundary    <= S_TOP;
              bottom_boundary <= S_BOTTOM;
            end else begin
              miss_cnt <= miss_cnt + CNT_W'(1);
              locked   <= 1'b0;
            end
          end
          default: begin
            state    <= SEARCH;
            miss_cnt <= '0;
            locked   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_track_window_ctrl.sv
// Scoreboard bench for track_window_ctrl; expected windows predicted at EOF drive time.
module tb_track_window_ctrl;

  localparam int H_ACT    = 1280;
  localparam int V_ACT    = 720;
  localparam int MARGIN   = 16;
  localparam int MIN_SIZE = 8;
  localparam int LOST_MAX = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] RGB_x_Src = '0;
  logic [9:0]  RGB_y_Src = '0;
  logic [10:0] Left = '0, Right = '0;
  logic [9:0]  Top = '0, Bottom = '0;
  logic [10:0] left_boundary, right_boundary;
  logic [9:0]  top_boundary, bottom_boundary;
  logic        locked, frame_tick;

  track_window_ctrl #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .MARGIN(MARGIN), .MIN_SIZE(MIN_SIZE), .LOST_MAX(LOST_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .RGB_x_Src(RGB_x_Src), .RGB_y_Src(RGB_y_Src),
    .Left(Left), .Right(Right), .Top(Top), .Bottom(Bottom),
    .left_boundary(left_boundary), .right_boundary(right_boundary),
    .top_boundary(top_boundary), .bottom_boundary(bottom_boundary),
    .locked(locked), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int unsigned cyc;
    int l, r, t, b;
    bit lk;
  } exp_t;

  exp_t sbq[$];

  // Reference model state and the values the outputs should currently show.
  int m_state, m_cnt, m_l, m_r, m_t, m_b;
  exp_t cur;

  function automatic int clampv(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0;
    m_l = 2; m_r = H_ACT - 2; m_t = 1; m_b = V_ACT - 2;
    cur.cyc = 0; cur.l = m_l; cur.r = m_r; cur.t = m_t; cur.b = m_b; cur.lk = 1'b0;
    sbq.delete();
  endtask

  task automatic model_eof(input int L, input int R, input int T, input int B);
    exp_t e;
    bit hit;
    int nl, nr, nt, nb, al, ar, at, ab;
    hit = (R >= L + MIN_SIZE) && (B >= T + MIN_SIZE);
    nl = clampv(L - MARGIN, 2, H_ACT - 2);
    nr = clampv(R + MARGIN, 2, H_ACT - 2);
    nt = clampv(T - MARGIN, 1, V_ACT - 2);
    nb = clampv(B + MARGIN, 1, V_ACT - 2);
`ifdef TRACK_SMOOTH_EN
    al = (m_l + nl) / 2; ar = (m_r + nr) / 2; at = (m_t + nt) / 2; ab = (m_b + nb) / 2;
`else
    al = nl; ar = nr; at = nt; ab = nb;
`endif
    if (m_state == 0) begin
      if (hit) begin m_state = 1; m_l = nl; m_r = nr; m_t = nt; m_b = nb; end
    end else if (hit) begin
      m_state = 1; m_cnt = 0; m_l = al; m_r = ar; m_t = at; m_b = ab;
    end else if (m_state == 1) begin
      m_state = 2; m_cnt = 1;
    end else if (m_cnt == LOST_MAX - 1) begin
      m_state = 0; m_cnt = 0; m_l = 2; m_r = H_ACT - 2; m_t = 1; m_b = V_ACT - 2;
    end else begin
      m_cnt++;
    end
    e.cyc = cyc + 2; e.l = m_l; e.r = m_r; e.t = m_t; e.b = m_b; e.lk = (m_state == 1);
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      RGB_x_Src = 11'($urandom_range(0, H_ACT - 2));
      RGB_y_Src = 10'($urandom_range(0, V_ACT - 1));
      Left = 11'($urandom); Right = 11'($urandom);
      Top = 10'($urandom); Bottom = 10'($urandom);
    end
  endtask

  task automatic frame(input int L, input int R, input int T, input int B, input int eof_len);
    @(posedge clk); #1;
    RGB_x_Src = 11'(H_ACT - 1); RGB_y_Src = 10'(V_ACT - 1);
    Left = 11'(L); Right = 11'(R); Top = 10'(T); Bottom = 10'(B);
    model_eof(L, R, T, B);
    repeat (eof_len - 1) @(posedge clk);
    idle(5);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_win(input string tag, input int l, input int r, input int t, input int b,
                           input bit lk);
    check({tag, "_left"}, 64'(left_boundary), 64'(l));
    check({tag, "_right"}, 64'(right_boundary), 64'(r));
    check({tag, "_top"}, 64'(top_boundary), 64'(t));
    check({tag, "_bottom"}, 64'(bottom_boundary), 64'(b));
    check({tag, "_locked"}, 64'(locked), 64'(lk));
  endtask

  // Every cycle: a tick exactly when the scoreboard head is due, outputs held otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        cur = sbq.pop_front();
        check("tick", 64'(frame_tick), 64'd1);
        check("sb_left", 64'(left_boundary), 64'(cur.l));
        check("sb_right", 64'(right_boundary), 64'(cur.r));
        check("sb_top", 64'(top_boundary), 64'(cur.t));
        check("sb_bottom", 64'(bottom_boundary), 64'(cur.b));
        check("sb_locked", 64'(locked), 64'(cur.lk));
      end else begin
        check("tick_idle", 64'(frame_tick), 64'd0);
        check("hold", 64'({left_boundary, right_boundary, top_boundary, bottom_boundary, locked}),
              64'({11'(cur.l), 11'(cur.r), 10'(cur.t), 10'(cur.b), cur.lk}));
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    mon_en = 1'b1;
    do_reset(3);
    idle(3);
    check_win("reset", 2, 1278, 1, 718, 1'b0);

    frame(100, 107, 50, 150, 1);
    check_win("narrow", 2, 1278, 1, 718, 1'b0);

    frame(100, 200, 50, 150, 3);
    check_win("lock", 84, 216, 34, 166, 1'b1);

    frame(200, 300, 50, 150, 1);
`ifdef TRACK_SMOOTH_EN
    check_win("relock", 134, 266, 34, 166, 1'b1);
`else
    check_win("relock", 184, 316, 34, 166, 1'b1);
`endif
    frame(0, 0, 0, 0, 1);
    check_win("coast1", left_boundary == 11'd0 ? 1 : sbq.size() == 0 ? cur.l : 0,
              cur.r, cur.t, cur.b, 1'b0);
    frame(0, 0, 0, 0, 1);
    check("coast2_locked", 64'(locked), 64'd0);
    frame(0, 0, 0, 0, 2);
    check_win("lost", 2, 1278, 1, 718, 1'b0);

    frame(5, 1275, 3, 716, 1);
    check_win("clamp", 2, 1278, 1, 718, 1'b1);

    // Reset one cycle after EOF must cancel the pending update.
    @(posedge clk); #1;
    RGB_x_Src = 11'(H_ACT - 1); RGB_y_Src = 10'(V_ACT - 1);
    Left = 11'd300; Right = 11'd400; Top = 10'd100; Bottom = 10'd200;
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    RGB_x_Src = '0; RGB_y_Src = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);
    check_win("abort", 2, 1278, 1, 718, 1'b0);

    frame(100, 200, 50, 150, 1);
    check_win("fresh", 84, 216, 34, 166, 1'b1);

    for (int i = 0; i < 12; i++)
      frame($urandom_range(0, 1400), $urandom_range(0, 1400),
            $urandom_range(0, 760), $urandom_range(0, 760), 1 + (i % 2));

    idle(3);
    check("sb_empty", 64'(sbq.size()), 64'd0);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
